// File: rtl/aemb_xcon_if.sv
// ---------------------------------------------------------------------------
// aemb_xcon_if
//   Register-access bus of the AEMB exception/interrupt controller.
//   Software (master) issues one access per cfg_stb_i cycle; the controller
//   (slave) answers with a one-cycle cfg_ack_o and registered read data.
//
//   cfg_stb_i  access strobe           (master -> slave)
//   cfg_we_i   1 = write, 0 = read     (master -> slave)
//   cfg_adr_i  register select         (master -> slave)
//   cfg_dat_i  write data              (master -> slave)
//   cfg_dat_o  read data               (slave  -> master)
//   cfg_ack_o  access acknowledge      (slave  -> master)
// ---------------------------------------------------------------------------
interface aemb_xcon_if;
    logic        cfg_stb_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_adr_i;
    logic [31:0] cfg_dat_i;
    logic [31:0] cfg_dat_o;
    logic        cfg_ack_o;

    modport master (
        output cfg_stb_i, cfg_we_i, cfg_adr_i, cfg_dat_i,
        input  cfg_dat_o, cfg_ack_o
    );

    modport slave (
        input  cfg_stb_i, cfg_we_i, cfg_adr_i, cfg_dat_i,
        output cfg_dat_o, cfg_ack_o
    );
endinterface

// File: rtl/aemb_xcon.sv
// ---------------------------------------------------------------------------
// aemb_xcon
//   Exception/interrupt controller for the AEMB core. Synchronises NINT
//   asynchronous interrupt lines, keeps per-channel edge/level pending state,
//   masks and prioritises them (channel 0 highest) and raises rXCE when the
//   MSR, atomic-slot and pipeline-enable conditions allow.
//
//   gclk, grst      clock, synchronous active-high reset
//   gena            pipeline enable
//   int_i           asynchronous interrupt lines (active high)
//   rMSR_IE/BIP     MSR interrupt enable / break in progress
//   rATOM           atomic-slot flags (issue only when exactly one is set)
//   xce_ack_i       core has vectored to the channel on xvec_o
//   cfg             register port (slave side)
//                     adr 0 IPR  pending status, read only
//                     adr 1 IMR  channel enable
//                     adr 2 IMD  channel mode, 1 = edge, 0 = level
//                     adr 3 ICR  write-1-to-clear edge pending, reads 0
//   rXCE            exception code, 2'o2 = interrupt, 2'o0 = none
//   xvec_o          highest-priority active channel, 0 when none
//   xpend_o         any channel pending and enabled (ungated)
// ---------------------------------------------------------------------------
module aemb_xcon #(
    parameter int NINT = 4,
    parameter int SYNC = 2,
    parameter int VECW = 3
) (
    input  logic             gclk,
    input  logic             grst,
    input  logic             gena,
    input  logic [NINT-1:0]  int_i,
    input  logic             rMSR_IE,
    input  logic             rMSR_BIP,
    input  logic [1:0]       rATOM,
    input  logic             xce_ack_i,
    aemb_xcon_if.slave       cfg,
    output logic [1:0]       rXCE,
    output logic [VECW-1:0]  xvec_o,
    output logic             xpend_o
);

    // Synchroniser chain, stage SYNC-1 is the synchronised level s.
    logic [SYNC-1:0][NINT-1:0] sync_q, sync_d;
    logic [NINT-1:0]           prev_q, prev_d;
    logic [NINT-1:0]           lat_q,  lat_d;
    logic [NINT-1:0]           imr_q,  imr_d;
    logic [NINT-1:0]           imd_q,  imd_d;
    logic                      rena_q, rena_d;
    logic                      cfg_ack_q, cfg_ack_d;
    logic [31:0]               cfg_dat_q, cfg_dat_d;

    logic [NINT-1:0] sync_s;
    logic [NINT-1:0] rise;
    logic [NINT-1:0] ipr;
    logic [NINT-1:0] active;
    logic [NINT-1:0] clr;
    logic [NINT-1:0] wdat;
    logic [VECW-1:0] vec;
    logic            pend;
    logic            wr;
    logic            rd;
    logic            fire;
    logic            unused_dat;

    // Only the low NINT data bits carry register content.
    assign unused_dat = ^cfg.cfg_dat_i[31:NINT];

    always_comb begin
        sync_s = sync_q[SYNC-1];
        rise   = sync_s & ~prev_q;
        // Edge channels report the latch, level channels the live input.
        ipr    = (imd_q & lat_q) | (~imd_q & sync_s);
        active = ipr & imr_q;
        pend   = |active;
        wdat   = cfg.cfg_dat_i[NINT-1:0];
        wr     = cfg.cfg_stb_i & cfg.cfg_we_i;
        rd     = cfg.cfg_stb_i & ~cfg.cfg_we_i;
    end

    // Priority encoder: the lowest active index wins.
    always_comb begin
        vec = '0;
        for (int i = NINT - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec = VECW'(i);
            end
        end
    end

    // Clear sources for the edge latches. The ack only clears when a channel
    // is actually being presented, so a stray ack cannot drop a masked ch0.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NINT; i++) begin
            clr[i] = (wr && cfg.cfg_adr_i == 2'd3 && wdat[i])
                   | (xce_ack_i && pend && vec == VECW'(i));
        end
    end

    always_comb begin
        sync_d = {sync_q[SYNC-2:0], int_i};
        prev_d = sync_s;
        rena_d = gena;

        imr_d = imr_q;
        if (wr && cfg.cfg_adr_i == 2'd1) begin
            imr_d = wdat;
        end

        imd_d = imd_q;
        if (wr && cfg.cfg_adr_i == 2'd2) begin
            imd_d = wdat;
        end

        // Set beats clear; masking with the next mode empties the latch of
        // any channel that is (or is becoming) level-sensitive.
        lat_d = ((lat_q & ~clr) | rise) & imd_d;

        cfg_ack_d = cfg.cfg_stb_i;
        cfg_dat_d = cfg_dat_q;
        if (rd) begin
            case (cfg.cfg_adr_i)
                2'd0:    cfg_dat_d = {{(32-NINT){1'b0}}, ipr};
                2'd1:    cfg_dat_d = {{(32-NINT){1'b0}}, imr_q};
                2'd2:    cfg_dat_d = {{(32-NINT){1'b0}}, imd_q};
                default: cfg_dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            sync_q    <= '0;
            prev_q    <= '0;
            lat_q     <= '0;
            imr_q     <= '0;
            imd_q     <= '1;
            rena_q    <= 1'b0;
            cfg_ack_q <= 1'b0;
            cfg_dat_q <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            lat_q     <= lat_d;
            imr_q     <= imr_d;
            imd_q     <= imd_d;
            rena_q    <= rena_d;
            cfg_ack_q <= cfg_ack_d;
            cfg_dat_q <= cfg_dat_d;
        end
    end

    // Combinational from registered state, matching the core's other
    // exception sources.
    always_comb begin
        fire = rena_q & (^rATOM) & ~rMSR_BIP & rMSR_IE & pend;
        rXCE = fire ? 2'o2 : 2'o0;
    end

    assign xvec_o        = vec;
    assign xpend_o       = pend;
    assign cfg.cfg_ack_o = cfg_ack_q;
    assign cfg.cfg_dat_o = cfg_dat_q;

endmodule

// File: tb/tb_aemb_xcon.sv
// ---------------------------------------------------------------------------
// tb_aemb_xcon
//   Directed and randomised stimulus for aemb_xcon (NINT=4, SYNC=2, VECW=3).
//   A behavioural model (input history queue, pending set, mask/mode words)
//   predicts every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_aemb_xcon;
    localparam int NINT = 4;
    localparam int SYNC = 2;
    localparam int VECW = 3;

    logic            gclk = 1'b0;
    logic            grst;
    logic            gena;
    logic [NINT-1:0] int_i;
    logic            rMSR_IE;
    logic            rMSR_BIP;
    logic [1:0]      rATOM;
    logic            xce_ack_i;
    logic [1:0]      rXCE;
    logic [VECW-1:0] xvec_o;
    logic            xpend_o;

    aemb_xcon_if bus ();

    aemb_xcon #(.NINT(NINT), .SYNC(SYNC), .VECW(VECW)) dut (
        .gclk      (gclk),
        .grst      (grst),
        .gena      (gena),
        .int_i     (int_i),
        .rMSR_IE   (rMSR_IE),
        .rMSR_BIP  (rMSR_BIP),
        .rATOM     (rATOM),
        .xce_ack_i (xce_ack_i),
        .cfg       (bus),
        .rXCE      (rXCE),
        .xvec_o    (xvec_o),
        .xpend_o   (xpend_o)
    );

    always #5 gclk = ~gclk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [NINT-1:0] m_hist[$];   // input samples, front = oldest = synchronised level
    logic [NINT-1:0] m_p;
    logic [NINT-1:0] m_lat;
    logic [NINT-1:0] m_imr;
    logic [NINT-1:0] m_imd;
    logic            m_rena;
    logic            m_ack;
    logic [31:0]     m_dat;

    function automatic logic [NINT-1:0] m_ipr();
        return (m_imd & m_lat) | (~m_imd & m_hist[0]);
    endfunction

    function automatic logic [NINT-1:0] m_active();
        return m_ipr() & m_imr;
    endfunction

    function automatic int m_vec();
        logic [NINT-1:0] a;
        logic [NINT-1:0] low;
        a = m_active();
        if (a == '0) return 0;
        low = a & (~a + 1'b1);
        return $clog2(low);
    endfunction

    function automatic logic [1:0] m_xce();
        logic one_atom;
        one_atom = (rATOM == 2'b01) || (rATOM == 2'b10);
        return (m_rena && one_atom && !rMSR_BIP && rMSR_IE && m_active() != '0) ? 2'd2 : 2'd0;
    endfunction

    task automatic m_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
        m_p    = '0;
        m_lat  = '0;
        m_imr  = '0;
        m_imd  = '1;
        m_rena = 1'b0;
        m_ack  = 1'b0;
        m_dat  = '0;
    endtask

    // Advance the model by one clock edge using the inputs presented now.
    task automatic m_edge();
        logic [NINT-1:0] s, rise, clr, new_imd, wd;
        logic            wr;
        if (grst) begin
            m_reset();
            return;
        end
        s    = m_hist[0];
        rise = s & ~m_p;
        wd   = bus.cfg_dat_i[NINT-1:0];
        wr   = bus.cfg_stb_i && bus.cfg_we_i;
        clr  = '0;
        if (wr && bus.cfg_adr_i == 2'd3) clr = wd;
        if (xce_ack_i && m_active() != '0) clr[m_vec()] = 1'b1;
        new_imd = (wr && bus.cfg_adr_i == 2'd2) ? wd : m_imd;
        m_ack = bus.cfg_stb_i;
        if (bus.cfg_stb_i && !bus.cfg_we_i) begin
            case (bus.cfg_adr_i)
                2'd0:    m_dat = 32'(m_ipr());
                2'd1:    m_dat = 32'(m_imr);
                2'd2:    m_dat = 32'(m_imd);
                default: m_dat = 32'd0;
            endcase
        end
        if (wr && bus.cfg_adr_i == 2'd1) m_imr = wd;
        m_lat = ((m_lat & ~clr) | rise) & new_imd;
        m_imd = new_imd;
        m_p   = s;
        m_hist.push_back(int_i);
        void'(m_hist.pop_front());
        m_rena = gena;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rXCE",      32'(rXCE),          32'(m_xce()));
        chk("xvec_o",    32'(xvec_o),        32'(m_vec()));
        chk("xpend_o",   32'(xpend_o),       32'(m_active() != '0));
        chk("cfg_ack_o", 32'(bus.cfg_ack_o), 32'(m_ack));
        chk("cfg_dat_o", bus.cfg_dat_o,      m_dat);
    endtask

    task automatic tick();
        m_edge();
        @(posedge gclk);
        #1;
        check_outputs();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        bus.cfg_stb_i = 1'b1;
        bus.cfg_we_i  = 1'b1;
        bus.cfg_adr_i = a;
        bus.cfg_dat_i = d;
        tick();
        bus.cfg_stb_i = 1'b0;
        bus.cfg_we_i  = 1'b0;
        $display("cfg write adr=%0d dat=%08h", a, d);
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        bus.cfg_stb_i = 1'b1;
        bus.cfg_we_i  = 1'b0;
        bus.cfg_adr_i = a;
        tick();
        bus.cfg_stb_i = 1'b0;
        d = bus.cfg_dat_o;
        $display("cfg read  adr=%0d dat=%08h", a, d);
    endtask

    task automatic ack();
        xce_ack_i = 1'b1;
        tick();
        xce_ack_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rdat;

        grst          = 1'b1;
        gena          = 1'b1;
        int_i         = '0;
        rMSR_IE       = 1'b1;
        rMSR_BIP      = 1'b0;
        rATOM         = 2'b01;
        xce_ack_i     = 1'b0;
        bus.cfg_stb_i = 1'b0;
        bus.cfg_we_i  = 1'b0;
        bus.cfg_adr_i = '0;
        bus.cfg_dat_i = '0;
        m_reset();

        // Reset state and register readback.
        repeat (3) tick();
        grst = 1'b0;
        tick();
        chk("reset_rXCE", 32'(rXCE),   32'd0);
        chk("reset_xvec", 32'(xvec_o), 32'd0);
        cfg_read(2'd0, rdat); chk("reset_IPR", rdat, 32'h0);
        cfg_read(2'd1, rdat); chk("reset_IMR", rdat, 32'h0);
        cfg_read(2'd2, rdat); chk("reset_IMD", rdat, 32'hF);
        cfg_read(2'd3, rdat); chk("reset_ICR", rdat, 32'h0);

        // One-cycle pulse on ch2: request exactly SYNC+1 edges later.
        cfg_write(2'd1, 32'hF);
        int_i = 4'b0100;
        tick();
        int_i = '0;
        repeat (SYNC - 1) tick();
        chk("ch2_early_rXCE", 32'(rXCE), 32'd0);
        tick();
        chk("ch2_rXCE", 32'(rXCE),   32'd2);
        chk("ch2_xvec", 32'(xvec_o), 32'd2);
        ack();
        chk("ch2_acked_rXCE", 32'(rXCE), 32'd0);

        // Simultaneous edges on ch3 and ch1: priority then sequential acks.
        int_i = 4'b1010;
        tick();
        int_i = '0;
        repeat (SYNC) tick();
        chk("prio_first",  32'(xvec_o), 32'd1);
        chk("prio_rXCE",   32'(rXCE),   32'd2);
        ack();
        chk("prio_second", 32'(xvec_o), 32'd3);
        ack();
        cfg_read(2'd0, rdat); chk("prio_IPR_empty", rdat, 32'h0);

        // Masked edge is still latched; unmasking raises the request.
        cfg_write(2'd1, 32'h0);
        int_i = 4'b0001;
        tick();
        int_i = '0;
        repeat (SYNC + 1) tick();
        cfg_read(2'd0, rdat); chk("masked_IPR", rdat, 32'h1);
        chk("masked_rXCE", 32'(rXCE), 32'd0);
        cfg_write(2'd1, 32'h1);
        chk("unmask_rXCE", 32'(rXCE), 32'd2);
        rATOM = 2'b00; #1; chk("atom00_rXCE", 32'(rXCE), 32'd0);
        rATOM = 2'b11; #1; chk("atom11_rXCE", 32'(rXCE), 32'd0);
        rATOM = 2'b10; #1; chk("atom10_rXCE", 32'(rXCE), 32'd2);
        rMSR_BIP = 1'b1; #1; chk("bip_rXCE", 32'(rXCE), 32'd0);
        rMSR_BIP = 1'b0;
        rATOM = 2'b01;
        cfg_write(2'd3, 32'h1);
        chk("icr_rXCE", 32'(rXCE), 32'd0);

        // Level channel: ack has no effect, IPR follows the line.
        cfg_write(2'd1, 32'hF);
        cfg_write(2'd2, 32'hD);
        int_i = 4'b0010;
        repeat (SYNC) tick();
        chk("level_xvec", 32'(xvec_o), 32'd1);
        chk("level_rXCE", 32'(rXCE),   32'd2);
        ack();
        cfg_read(2'd0, rdat); chk("level_after_ack", rdat, 32'h2);
        int_i = '0;
        repeat (SYNC) tick();
        cfg_read(2'd0, rdat); chk("level_dropped", rdat, 32'h0);

        // New ch0 edge in the same cycle as an ICR clear of an older one.
        cfg_write(2'd2, 32'hF);
        int_i = 4'b0001;
        tick();
        int_i = '0;
        repeat (SYNC + 2) tick();
        int_i = 4'b0001;
        tick();
        int_i = '0;
        repeat (SYNC - 1) tick();
        cfg_write(2'd3, 32'h1);
        cfg_read(2'd0, rdat); chk("set_beats_clear", rdat, 32'h1);
        cfg_write(2'd3, 32'h1);

        // Randomised traffic with a reset dropped in mid-stream.
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < NINT; b++) begin
                if ($urandom % 8 == 0) int_i[b] = ~int_i[b];
            end
            gena     = ($urandom % 4) != 0;
            rATOM    = 2'($urandom);
            rMSR_IE  = ($urandom % 8) != 0;
            rMSR_BIP = ($urandom % 8) == 0;
            if ($urandom % 5 == 0) begin
                bus.cfg_stb_i = 1'b1;
                bus.cfg_we_i  = 1'($urandom);
                bus.cfg_adr_i = 2'($urandom);
                bus.cfg_dat_i = $urandom;
            end else begin
                bus.cfg_stb_i = 1'b0;
                bus.cfg_we_i  = 1'b0;
            end
            xce_ack_i = (m_active() != '0) && ($urandom % 3 == 0);
            grst = (n == 200);
            tick();
            if (n == 200) begin
                chk("midrst_rXCE",  32'(rXCE),          32'd0);
                chk("midrst_xvec",  32'(xvec_o),        32'd0);
                chk("midrst_xpend", 32'(xpend_o),       32'd0);
                chk("midrst_ack",   32'(bus.cfg_ack_o), 32'd0);
                chk("midrst_dat",   bus.cfg_dat_o,      32'd0);
            end
        end
        grst          = 1'b0;
        xce_ack_i     = 1'b0;
        bus.cfg_stb_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aemb_xcon.md
# aemb_xcon

Parametrised exception/interrupt controller for the AEMB core, replacing the single-input interrupt latch in the system control unit. It synchronises NINT external interrupt lines and supports per-channel edge or level mode, masking and fixed priority. It presents one exception request plus a channel vector to the pipeline, gated by the MSR, atomic-slot and pipeline-enable conditions. A small register port lets software set the mask and mode, read pending status and clear pending bits.

## Interface
- NINT, 4: number of interrupt channels, 1..8.
- SYNC, 2: input synchroniser depth in flops, minimum 2.
- VECW, 3: vector width; must satisfy 2^VECW >= NINT.

- gclk  in  1  core clock.
- grst  in  1  reset, synchronous, active-high.
- gena  in  1  pipeline enable (1 = pipeline advancing this cycle).
- int_i  in  NINT  asynchronous interrupt lines, active-high.
- rMSR_IE  in  1  MSR interrupt enable.
- rMSR_BIP  in  1  MSR break-in-progress.
- rATOM  in  2  atomic-slot flags; a request may issue only when ^rATOM = 1.
- xce_ack_i  in  1  one-cycle pulse: the core has vectored to the interrupt presented on xvec_o.
- cfg_stb_i  in  1  register access strobe.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_adr_i  in  2  register select.
- cfg_dat_i  in  32  write data.
- cfg_dat_o  out  32  read data; 0 at reset.
- cfg_ack_o  out  1  access acknowledge; 0 at reset.
- rXCE  out  2  exception code: 2'o2 = interrupt, 2'o0 = none.
- xvec_o  out  VECW  number of the highest-priority active channel; 0 when none is active.
- xpend_o  out  1  OR of all active channels (pending AND mask), whether or not the request is gated.

## Operation
- Synchroniser: SYNC flops per channel, reset 0. The last stage is s. A second flop p holds the previous value of s, reset 0. The rising-edge detector is rise = s & ~p.
- Registers, bits [NINT-1:0]. Upper bits read as 0 and ignore writes.
  - adr 0, IPR: pending status, read-only. Writes are ignored.
  - adr 1, IMR: per-channel enable, 1 = enabled. Reset 0.
  - adr 2, IMD: per-channel mode, 1 = edge, 0 = level. Reset all 1.
  - adr 3, ICR: write-1-to-clear for edge-mode pending bits. Reads as 0.
- Pending, edge channel: latch bit L[i] sets on rise[i]. It sets regardless of IMR and rMSR_IE, so no edge is lost while masked.
- Edge channel clear: L[i] clears on an ICR write with bit i = 1, or on xce_ack_i when xvec_o = i.
- Edge channel, simultaneous set and clear in one cycle: the set wins.
- Pending, level channel: IPR[i] = s[i] directly. Ack and ICR have no effect. Software must clear the source.
- Switching IMD[i] from edge to level clears L[i].
- active = IPR & IMR. xvec_o is the lowest set index of active (channel 0 has the highest priority).
- rENA flop: rENA <= gena, reset 0.
- fire = rENA & ^rATOM & ~rMSR_BIP & rMSR_IE & |active.
- rXCE = fire ? 2'o2 : 2'o0. This is combinational from registered state and inputs, the same as the existing exception path.
- Register port: one access per cfg_stb_i. cfg_ack_o pulses for exactly one cycle, on the cycle after the strobe.
- Read data is registered with the ack and holds until the next read.
- Write effects are visible in the cycle after the strobe.
- A strobe held high for several cycles gives one ack per cycle of strobe.

## Timing
- Input latency: int_i rises before edge k. Then s is high after edge k+SYNC-1, and L is set after edge k+SYNC. rXCE can assert in that same cycle.
- Level channel latency: IPR follows s, one cycle earlier than the edge-mode path.
- Ack: the pending bit is cleared after the ack edge. The next-priority channel appears on xvec_o and rXCE in the following cycle.
- grst at any time clears every flop: L, synchroniser stages, p, IMR, rENA, cfg_dat_o and cfg_ack_o. IMD is set to all 1.
- Edges in flight are discarded on reset. Outputs read 0 / 2'o0 in the first cycle after reset.
- An edge on int_i that lasts one gclk is still captured.
- An edge shorter than one gclk is not guaranteed to be captured.

## Test plan
- Reset, then read all four registers: IPR=0, IMR=0, IMD=0x0F (NINT=4), ICR=0. rXCE=0, xvec_o=0.
- IMR=0xF, IE=1, BIP=0, rATOM=2'b01, gena=1. Pulse int_i[2] for 1 cycle. Required: rXCE=2'o2 and xvec_o=2 exactly SYNC+1 edges later. Ack clears it, rXCE=0 on the next cycle.
- Edges on channels 3 and 1 in the same cycle: xvec_o=1 first. After the ack, xvec_o=3. After a second ack, IPR=0.
- IMR=0, edge on ch0: IPR=0x1, rXCE=0. Then write IMR=0x1: rXCE=2'o2 on the next cycle. With rATOM=2'b00 or BIP=1, rXCE stays 0.
- Ch1 set to level mode, int_i[1] held high: ack leaves IPR[1]=1. Drop int_i[1]: IPR[1]=0 after SYNC edges.
- Edge on ch0 in the same cycle as an ICR write of 0x1 clearing an earlier ch0 pending: IPR[0] stays 1. Assert grst mid-stream: all outputs read 0 next cycle.
